// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind scorer slice.
// Latency: n/a (types, constants and a peg-extract helper only).
// Backpressure: n/a.
package mastermind_pkg;

  localparam int COLOR_W    = 3;
  localparam int NUM_PEGS   = 4;
  localparam int NUM_COLORS = 7;
  localparam int WORD_W     = COLOR_W * NUM_PEGS;
  localparam logic [COLOR_W-1:0] COLOR_EMPTY = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXACT  = 2'd1,
    ST_COLOR  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Peg p lives in bits [3p+2:3p] of a packed guess/answer word.
  function automatic logic [COLOR_W-1:0] peg(input logic [WORD_W-1:0] w, input int p);
    return w[p*COLOR_W +: COLOR_W];
  endfunction

endpackage

// File: rtl/mastermind_history.sv
// Per-game history register file: {guess, exact, partial} per guess slot.
// Latency: write lands on the next Clk edge; read is combinational.
// Backpressure: none; a write is always accepted, out-of-range indices are ignored/read as 0.
//
// Ports: Clk, Reset (async, active-high), clear (sync wipe, wins over wr_en),
//        wr_en/wr_idx/wr_dat write port, rd_idx/rd_dat combinational read port.
module mastermind_history #(
  parameter int NUM_GUESSES = 6,
  parameter int SLOT_W      = 3,
  parameter int ENTRY_W     = 18
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [SLOT_W-1:0]  wr_idx,
  input  logic [ENTRY_W-1:0] wr_dat,
  input  logic [SLOT_W-1:0]  rd_idx,
  output logic [ENTRY_W-1:0] rd_dat
);

  localparam logic [SLOT_W:0] DEPTH = NUM_GUESSES[SLOT_W:0];

  logic [ENTRY_W-1:0] mem [NUM_GUESSES];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_GUESSES; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_GUESSES; i++) mem[i] <= '0;
    end else if (wr_en && ({1'b0, wr_idx} < DEPTH)) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = ({1'b0, rd_idx} < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: exact hits then colour-only hits, result logged to history.
// Latency: done pulses 12 Clk after start is sampled in IDLE.
// Backpressure: start is ignored while busy (not queued); clear aborts a run with no done.
//
// Ports: Clk, Reset (async, active-high); start/guess/answer/slot request; clear new-game wipe;
//        busy/done handshake; exact/partial/win result; hist_count; rd_idx -> rd_guess/rd_exact/
//        rd_partial history read; selfcheck_err sticky reference-mismatch flag.
// Build option: define MM_SCORER_SELFCHECK_EN to add a single-cycle reference scorer that
//        cross-checks the accumulators at commit; otherwise selfcheck_err is tied 0.
module mastermind_scorer
  import mastermind_pkg::*;
#(
  parameter int NUM_GUESSES = 6,
  parameter int SLOT_W      = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [11:0]       guess,
  input  logic [11:0]       answer,
  input  logic [SLOT_W-1:0] slot,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic [2:0]        exact,
  output logic [2:0]        partial,
  output logic              win,
  output logic [SLOT_W-1:0] hist_count,
  input  logic [SLOT_W-1:0] rd_idx,
  output logic [11:0]       rd_guess,
  output logic [2:0]        rd_exact,
  output logic [2:0]        rd_partial,
  output logic              selfcheck_err
);

  localparam int ENTRY_W = WORD_W + 6;
  localparam logic [SLOT_W:0] DEPTH = NUM_GUESSES[SLOT_W:0];

  state_t              state;
  logic [WORD_W-1:0]   g_q, a_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [1:0]          pos;
  logic [2:0]          col;
  logic [2:0]          exact_acc, partial_acc;
  logic [NUM_PEGS-1:0] mask;

  logic [2:0]          gc, ac, col_min;
  logic                peg_hit;
  logic                slot_ok;
  logic [SLOT_W:0]     slot_next;
  logic                hist_wr;
  logic [ENTRY_W-1:0]  rd_dat;

  // Per-colour counts over pegs not already claimed by an exact hit.
  always_comb begin
    gc = '0;
    ac = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (!mask[p] && peg(g_q, p) == col) gc = gc + 3'd1;
      if (!mask[p] && peg(a_q, p) == col) ac = ac + 3'd1;
    end
    col_min = (gc < ac) ? gc : ac;
  end

  assign peg_hit   = (peg(g_q, int'(pos)) == peg(a_q, int'(pos)));
  assign slot_ok   = ({1'b0, slot_q} < DEPTH);
  assign slot_next = {1'b0, slot_q} + 1'b1;
  assign hist_wr   = (state == ST_COMMIT) && slot_ok && !clear;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      g_q         <= '0;
      a_q         <= '0;
      slot_q      <= '0;
      pos         <= '0;
      col         <= '0;
      exact_acc   <= '0;
      partial_acc <= '0;
      mask        <= '0;
      done        <= 1'b0;
      exact       <= '0;
      partial     <= '0;
      win         <= 1'b0;
      hist_count  <= '0;
    end else if (clear) begin
      // exact/partial intentionally hold their last values across a new game.
      state      <= ST_IDLE;
      done       <= 1'b0;
      win        <= 1'b0;
      hist_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            g_q         <= guess;
            a_q         <= answer;
            slot_q      <= slot;
            exact_acc   <= '0;
            partial_acc <= '0;
            mask        <= '0;
            pos         <= '0;
            state       <= ST_EXACT;
          end
        end
        ST_EXACT: begin
          if (peg_hit) begin
            exact_acc <= exact_acc + 3'd1;
            mask[pos] <= 1'b1;
          end
          pos <= pos + 2'd1;
          if (pos == 2'd3) begin
            col   <= 3'd1;
            state <= ST_COLOR;
          end
        end
        ST_COLOR: begin
          partial_acc <= partial_acc + col_min;
          col         <= col + 3'd1;
          if (col == 3'(NUM_COLORS)) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          exact   <= exact_acc;
          partial <= partial_acc;
          win     <= (exact_acc == 3'd4);
          done    <= 1'b1;
          if (slot_ok && (slot_next > {1'b0, hist_count})) hist_count <= slot_next[SLOT_W-1:0];
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mastermind_history #(
    .NUM_GUESSES (NUM_GUESSES),
    .SLOT_W      (SLOT_W),
    .ENTRY_W     (ENTRY_W)
  ) u_history (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (clear),
    .wr_en  (hist_wr),
    .wr_idx (slot_q),
    .wr_dat ({g_q, exact_acc, partial_acc}),
    .rd_idx (rd_idx),
    .rd_dat (rd_dat)
  );

  assign rd_guess   = rd_dat[ENTRY_W-1:6];
  assign rd_exact   = rd_dat[5:3];
  assign rd_partial = rd_dat[2:0];

`ifdef MM_SCORER_SELFCHECK_EN
  logic [2:0] ref_exact, ref_partial;
  logic [2:0] rgc, rac;
  logic [NUM_PEGS-1:0] ref_mask;

  // Whole score in one combinational pass over the latched operands.
  always_comb begin
    ref_exact   = '0;
    ref_partial = '0;
    ref_mask    = '0;
    rgc         = '0;
    rac         = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (peg(g_q, p) == peg(a_q, p)) begin
        ref_exact   = ref_exact + 3'd1;
        ref_mask[p] = 1'b1;
      end
    end
    for (int c = 0; c <= NUM_COLORS; c++) begin
      rgc = '0;
      rac = '0;
      for (int p = 0; p < NUM_PEGS; p++) begin
        if (!ref_mask[p] && peg(g_q, p) == 3'(c)) rgc = rgc + 3'd1;
        if (!ref_mask[p] && peg(a_q, p) == 3'(c)) rac = rac + 3'd1;
      end
      if (3'(c) != COLOR_EMPTY) ref_partial = ref_partial + ((rgc < rac) ? rgc : rac);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      selfcheck_err <= 1'b0;
    else if (clear)
      selfcheck_err <= 1'b0;
    else if (state == ST_COMMIT && (ref_exact != exact_acc || ref_partial != partial_acc))
      selfcheck_err <= 1'b1;
  end
`else
  assign selfcheck_err = 1'b0;
`endif

endmodule
